// File: rtl/updown_counter.sv
// Modulo-2^WIDTH up/down counter with asynchronous active-high clear.
// Steps on every rising clock edge and wraps naturally at both ends.
module updown_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             dir_up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Unsigned WIDTH-bit arithmetic gives the 7->0 and 0->7 wraps for free.
  always_comb begin
    count_d = count_q;
    if (dir_up) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; clear sits in the sensitivity list to act without a clock.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: table-driven vectors for WIDTH=3
// plus hand-written sequences for async clear, toggling and WIDTH=4 wrap.
`timescale 1ns/1ps
module tb_updown_counter;

  typedef struct {
    logic       clear;
    logic       dir_up;
    logic [2:0] exp_count;
  } vec_t;

  logic       clk;
  logic       clear;
  logic       dir_up;
  logic [2:0] count;

  logic       clear4;
  logic       dir_up4;
  logic [3:0] count4;

  int n_checks;
  int n_errors;

  vec_t main_tbl[$];
  vec_t tog_tbl[$];

  updown_counter #(.WIDTH(3)) dut (
    .clk    (clk),
    .clear  (clear),
    .dir_up (dir_up),
    .count  (count)
  );

  updown_counter #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .clear  (clear4),
    .dir_up (dir_up4),
    .count  (count4)
  );

  // 20 ns period, first rising edge at 10 ns.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic d, input logic [2:0] e);
    vec_t v;
    v.clear     = c;
    v.dir_up    = d;
    v.exp_count = e;
    return v;
  endfunction

  // Inputs change on the falling edge; the output is sampled 5 ns after the rising edge.
  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clk);
    clear  = v.clear;
    dir_up = v.dir_up;
    @(posedge clk);
    #5;
    check(name, {1'b0, count}, {1'b0, v.exp_count});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset hold: edges at 30..90 with clear=1, dir_up=0.
    for (int i = 0; i < 4; i++) main_tbl.push_back(mk(1'b1, 1'b0, 3'd0));
    // Release at 100 ns and count up through the 7->0 wrap.
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd1));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd2));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd3));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd4));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd5));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd6));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd7));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd0));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd1));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd2));
    // Count down from 2 through the 0->7 wrap.
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd1));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd0));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd7));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd6));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd5));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd4));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd3));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd2));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd1));
    main_tbl.push_back(mk(1'b0, 1'b0, 3'd0));
    // Up from 0 to 5, ready for the mid-count clear.
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd1));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd2));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd3));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd4));
    main_tbl.push_back(mk(1'b0, 1'b1, 3'd5));

    // After clear release: up to 3, then alternate direction every edge.
    tog_tbl.push_back(mk(1'b0, 1'b1, 3'd1));
    tog_tbl.push_back(mk(1'b0, 1'b1, 3'd2));
    tog_tbl.push_back(mk(1'b0, 1'b1, 3'd3));
    tog_tbl.push_back(mk(1'b0, 1'b1, 3'd4));
    tog_tbl.push_back(mk(1'b0, 1'b0, 3'd3));
    tog_tbl.push_back(mk(1'b0, 1'b1, 3'd4));
    tog_tbl.push_back(mk(1'b0, 1'b0, 3'd3));

    clear   = 1'b1;
    dir_up  = 1'b0;
    clear4  = 1'b1;
    dir_up4 = 1'b0;

    #5;
    check("reset_w3", {1'b0, count}, 4'd0);
    check("reset_w4", count4, 4'd0);
    @(posedge clk);
    #5;
    check("reset_hold_edge10", {1'b0, count}, 4'd0);

    foreach (main_tbl[i]) apply_vec($sformatf("main_vec%0d", i), main_tbl[i]);

    // Async clear while at 5: assert mid high phase, observe before next edge.
    #3;
    clear = 1'b1;
    #1;
    check("async_clear_immediate", {1'b0, count}, 4'd0);
    @(posedge clk);
    #5;
    check("clear_beats_edge", {1'b0, count}, 4'd0);

    foreach (tog_tbl[i]) apply_vec($sformatf("resume_toggle_vec%0d", i), tog_tbl[i]);

    // WIDTH=4: clear already held; release, one down step wraps to 15.
    @(negedge clk);
    clear4  = 1'b0;
    dir_up4 = 1'b0;
    @(posedge clk);
    #5;
    check("w4_down_wrap", count4, 4'd15);

    @(negedge clk);
    clear4 = 1'b1;
    #1;
    check("w4_async_clear", count4, 4'd0);
    #4;
    clear4  = 1'b0;
    dir_up4 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #5;
      check($sformatf("w4_up_step%0d", i), count4, 4'(i % 16));
    end

    // The WIDTH=3 counter kept stepping down-toggled direction meanwhile; re-check it is live.
    @(negedge clk);
    clear  = 1'b1;
    #1;
    check("w3_final_clear", {1'b0, count}, 4'd0);
    dir_up = 1'b0;
    #2;
    clear  = 1'b0;
    @(posedge clk);
    #5;
    check("w3_final_down_wrap", {1'b0, count}, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
